reset_button_conditioner: RTL
=============================

Name: reset_button_conditioner

Overview:
- Produces the `user_reset` request consumed by the power-on reset generator, from a raw, bouncy, asynchronous push-button.
- Synchronises and debounces the button, and emits single-cycle press/release pulses for game logic.
- Issues a fixed-width `user_reset` pulse only after the button is held continuously for a long-press interval, so accidental taps do not reset the projector.

Parameters:
- DEBOUNCE_CYCLES, 650000, cycles the synchronised input must differ from the debounced state before the state flips (~10 ms at 65 MHz); must be >= 1.
- HOLD_CYCLES, 65000000, cycles of continuous debounced press before `user_reset` fires (~1 s); must be >= 1.
- STRETCH_CYCLES, 16, width of the `user_reset` pulse in cycles; must be >= 1.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; must come from the power-on generator's timer only, never from a path that includes `user_reset`
- btn_raw  input  1  raw asynchronous button pin
- btn_state  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one-cycle pulse on the debounced 0->1 transition
- release_pulse  output  1  one-cycle pulse on the debounced 1->0 transition
- user_reset  output  1  long-press reset request, STRETCH_CYCLES wide

Behaviour:
- Clocking and reset: one clock `clk`. Reset is synchronous and active-high: every register clears on a rising edge of `clk` while `reset` = 1.
- Reset values: `btn_state`, `press_pulse`, `release_pulse` and `user_reset` = 0. Sync flops load the unpressed raw level (1 if ACTIVE_LOW, else 0). All counters = 0. `armed` = 1.
- Polarity: input is normalised after the sync stage as pressed = sync2 XOR ACTIVE_LOW.
- Synchroniser: two flops, sync1 <= btn_raw, sync2 <= sync1. Logic never uses btn_raw directly.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
  - If pressed == btn_state, the counter clears.
  - Otherwise it increments. On the edge where it would reach DEBOUNCE_CYCLES, `btn_state` toggles and the counter clears.
  - Any glitch back to btn_state before terminal count clears the counter; no partial credit is kept.
- Latency: a clean raw change sampled at edge k reaches sync2 at edge k+1. `btn_state` changes at edge k+1+DEBOUNCE_CYCLES.
- Pulses: `press_pulse` and `release_pulse` are registered and asserted in the cycle after `btn_state` changes, for exactly 1 cycle. They are never asserted together.
- Hold counter, width $clog2(HOLD_CYCLES+1):
  - Counts while `btn_state` = 1 and `armed` = 1; clears whenever `btn_state` = 0.
  - On reaching HOLD_CYCLES: load the stretch counter with STRETCH_CYCLES, clear `armed`, and clear the hold counter.
- Re-arm: `armed` is set again only when `btn_state` returns to 0. This gives exactly one `user_reset` per press, regardless of hold length.
- Stretch: `user_reset` = (stretch counter != 0), registered; the counter decrements to 0. A release during the stretch does not shorten it. A new trigger cannot occur during the stretch because `armed` = 0.
- State machine (`armed` plus stretch, expressed as states):
  - IDLE -> HOLDING on `btn_state` rising.
  - HOLDING -> IDLE on release.
  - HOLDING -> FIRING at the HOLD_CYCLES terminal count.
  - FIRING -> SPENT after STRETCH_CYCLES cycles.
  - SPENT -> IDLE on release.
- Reset mid-operation: any state returns to IDLE in one edge. An in-progress `user_reset` pulse is truncated; downstream must tolerate this.
- Integration rule: feeding the combined reset back into this block's `reset` would let `user_reset` truncate itself after one cycle, so this block's `reset` must exclude `user_reset`.

Decomposition:
- Shared package holds the state encoding (IDLE, HOLDING, FIRING, SPENT) and the default cycle constants tied to the 65 MHz clock.
- One natural sub-module: `sync_debounce` (synchroniser, debounce counter, btn_state). It is reusable for the flipper and launcher buttons.
- The top level adds edge pulses, the hold FSM and the stretch counter.

Test Plan:
Bench parameters are DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STRETCH_CYCLES=3, ACTIVE_LOW=1.
- Reset: hold `reset` 2 cycles with btn_raw=0 -> all outputs 0; `btn_state` stays 0 until reset drops and the debounce completes.
- Clean press: drive btn_raw 1->0 at edge 0 -> `btn_state` 1 at edge 5; `press_pulse` high only at edge 6.
- Bounce rejection: toggle btn_raw every 3 cycles for 30 cycles -> `btn_state`, `press_pulse` and `user_reset` all remain 0.
- Short press: hold pressed 6 cycles after `btn_state` rises, then release -> no `user_reset`; one `release_pulse` after the debounce completes.
- Long press: hold 40 cycles -> `user_reset` high for exactly 3 cycles, starting 8 cycles after `btn_state` rises, exactly once. Release then re-press long -> fires again.
- Reset during FIRING: assert `reset` in the 2nd `user_reset` cycle -> `user_reset` 0 next edge. After reset drops with the button still held, the debounce and hold windows restart and `user_reset` fires again.

Source files
------------

// File: rtl/reset_button_conditioner_pkg.sv
// Shared definitions for the reset button conditioner: long-press FSM
// encoding and default cycle counts for the 65 MHz system clock.
package reset_button_conditioner_pkg;

    localparam int unsigned CLK_FREQ_HZ             = 65_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;  // ~10 ms
    localparam int unsigned DEFAULT_HOLD_CYCLES     = CLK_FREQ_HZ;        // ~1 s
    localparam int unsigned DEFAULT_STRETCH_CYCLES  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        FIRING  = 2'd2,
        SPENT   = 2'd3
    } hold_state_e;

endpackage

// File: rtl/reset_button_conditioner_sync_debounce.sv
// Two-flop synchroniser plus debounce counter for a raw push-button.
// Reusable for any mechanical button (reset, flippers, launcher).
module sync_debounce
    import reset_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_raw_i,
    output logic btn_state_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           UNPRESSED_LEVEL = ACTIVE_LOW;

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic [CW-1:0] cnt_q;
    logic          pressed;

    assign pressed     = sync2_q ^ ACTIVE_LOW;
    assign btn_state_o = state_q;

    // Any sample that agrees with the current state discards accumulated credit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= UNPRESSED_LEVEL;
            sync2_q <= UNPRESSED_LEVEL;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            if (pressed == state_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                state_q <= ~state_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_button_conditioner.sv
// Debounced push-button with press/release pulses and a long-press
// user_reset request of fixed width, issued once per press.
module reset_button_conditioner
    import reset_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned STRETCH_CYCLES  = DEFAULT_STRETCH_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic user_reset
);

    localparam int unsigned   HW           = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned   SW           = $clog2(STRETCH_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);

    logic          btn_level;
    logic          btn_prev_q;
    logic          press_q;
    logic          release_q;
    logic          user_reset_q;
    logic [HW-1:0] hold_q;
    logic [SW-1:0] stretch_q;
    hold_state_e   state_q;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_sync_debounce (
        .clk_i       (clk),
        .reset_i     (reset),
        .btn_raw_i   (btn_raw),
        .btn_state_o (btn_level)
    );

    assign btn_state     = btn_level;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign user_reset    = user_reset_q;

    // user_reset_q always equals (stretch_q != 0); it is kept as its own flop
    // so the output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q   <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            user_reset_q <= 1'b0;
            hold_q       <= '0;
            stretch_q    <= '0;
            state_q      <= IDLE;
        end else begin
            btn_prev_q <= btn_level;
            press_q    <= btn_level & ~btn_prev_q;
            release_q  <= ~btn_level & btn_prev_q;

            case (state_q)
                IDLE, HOLDING: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                        hold_q  <= '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q      <= FIRING;
                        hold_q       <= '0;
                        stretch_q    <= STRETCH_LOAD;
                        user_reset_q <= 1'b1;
                    end else begin
                        state_q <= HOLDING;
                        hold_q  <= hold_q + 1'b1;
                    end
                end
                FIRING: begin
                    hold_q <= '0;
                    if (stretch_q == STRETCH_ONE) begin
                        stretch_q    <= '0;
                        user_reset_q <= 1'b0;
                        state_q      <= SPENT;
                    end else begin
                        stretch_q <= stretch_q - 1'b1;
                    end
                end
                SPENT: begin
                    hold_q <= '0;
                    if (!btn_level) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
